// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide WIDTH*WORDS-bit adder that reuses one WIDTH-bit
// prefix_tree_adder over WORDS cycles, least-significant word first.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready accept a, b, cin;
// out_valid/out_ready return sum, cout. With MULTIWORD_ADD_SUB_EN defined,
// an extra sub input selects a-b (cout=1 means no borrow).

// prefix_tree_adder: Kogge-Stone adder; cin enters as the generate of an
// extra position below bit 0, so the top prefix generate is the carry-out.
module prefix_tree_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] gg, pp, gn, pn;
  always_comb begin
    gg = {a & b, cin};
    pp = {a ^ b, 1'b0};
    gn = '0;
    pn = '0;
    for (int l = 0; (1 << l) <= W; l++) begin
      gn = gg;
      pn = pp;
      for (int i = (1 << l); i <= W; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pn[i] = pp[i] & pp[i - (1 << l)];
      end
      gg = gn;
      pp = pn;
    end
    s = (a ^ b) ^ gg[W-1:0];
    cout = gg[W];
  end
endmodule

module multiword_add_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout
`ifdef MULTIWORD_ADD_SUB_EN
  ,
  input  logic                   sub
`endif
);
  localparam int N = WIDTH * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] add_s;
  logic add_c, sub_i, last;
`ifdef MULTIWORD_ADD_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  prefix_tree_adder #(.W(WIDTH)) u_add (
    .a(a_q[idx_q*WIDTH +: WIDTH]),
    .b(b_q[idx_q*WIDTH +: WIDTH]),
    .cin(carry_q),
    .s(add_s),
    .cout(add_c)
  );
  assign last = idx_q == IW'(WORDS - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    cout_d = cout_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    idx_d = idx_q;
    if (state_q == IDLE && in_valid) begin
      // subtraction is a + ~b + 1, so the inversion and the +1 happen at accept
      a_d = a;
      b_d = sub_i ? ~b : b;
      carry_d = sub_i | cin;
      idx_d = '0;
      in_ready_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d[idx_q*WIDTH +: WIDTH] = add_s;
      carry_d = add_c;
      idx_d = last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_d = add_c;
        out_valid_d = 1'b1;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      out_valid_d = 1'b0;
      in_ready_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      idx_q <= idx_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule
